// File: rtl/fetch_unit_if.sv
// fetch_unit_if: program-memory read port and decode-side instruction handshake of the fetch stage.
interface fetch_unit_if;
    logic        mem_re;
    logic [29:0] memaddr;
    logic [31:0] rmemdata;
    logic        redirect;
    logic [29:0] redirect_addr;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [29:0] inst_addr;
    modport master (
        output mem_re, memaddr, inst_valid, inst, inst_addr,
        input  rmemdata, redirect, redirect_addr, inst_ready
    );
    modport slave (
        input  mem_re, memaddr, inst_valid, inst, inst_addr,
        output rmemdata, redirect, redirect_addr, inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited sequential fetch into an instruction FIFO with redirect flush.
// Define FETCH_BYPASS_EN to present a response straight from memory when the FIFO is empty.
module fetch_unit #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [29:0] RESET_PC   = 30'h0
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    logic [29:0]   pc, rsp_addr;
    logic          inflight;
    logic [CW-1:0] count;
    logic [AW-1:0] head, tail;
    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [29:0]   fifo_addr [FIFO_DEPTH];
    logic          has_head, byp, push, pop;
    always_comb begin
        has_head = count != '0;
`ifdef FETCH_BYPASS_EN
        byp = inflight && !has_head && !bus.redirect;
`else
        byp = 1'b0;
`endif
        // an in-flight read already holds a slot, so it counts against the credit
        bus.mem_re     = rst && !bus.redirect && ((count + CW'(inflight)) < CW'(FIFO_DEPTH));
        bus.memaddr    = rst ? pc : '0;
        bus.inst_valid = !bus.redirect && (has_head || byp);
        bus.inst       = has_head ? fifo_data[head] : byp ? bus.rmemdata : '0;
        bus.inst_addr  = has_head ? fifo_addr[head] : byp ? rsp_addr : '0;
        push           = inflight && !bus.redirect && !(byp && bus.inst_ready);
        pop            = has_head && bus.inst_valid && bus.inst_ready;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= RESET_PC;
            inflight <= 1'b0;
            rsp_addr <= '0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else if (bus.redirect) begin
            pc       <= bus.redirect_addr;
            inflight <= 1'b0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            inflight <= bus.mem_re;
            if (bus.mem_re) begin
                pc       <= pc + 30'd1;
                rsp_addr <= pc;
            end
            if (push) tail <= tail + AW'(1);
            if (pop) head <= head + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[tail] <= bus.rmemdata;
            fifo_addr[tail] <= rsp_addr;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch/redirect stimulus with a queue scoreboard of the expected instruction stream.
module tb_fetch_unit;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif
    localparam int          DEPTH = 4;
    localparam logic [29:0] RPC   = 30'h0;
    logic clk = 1'b0;
    logic rst = 1'b0;
    fetch_unit_if bus();
    fetch_unit #(.FIFO_DEPTH(DEPTH), .RESET_PC(RPC)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
    } exp_t;
    exp_t        exp_q[$];
    logic [29:0] gen_pc, iss_pc;
    int total = 0, bad = 0, issued = 0, dlv = 0, ndel = 0;
    function automatic logic [31:0] rom(input logic [29:0] a);
        return 32'h1000_0000 + {2'b00, a};
    endfunction
    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction
    // the model: after a reset or redirect the stream is simply consecutive addresses
    function automatic void refill();
        while (exp_q.size() < 16) begin
            exp_q.push_back('{gen_pc, rom(gen_pc)});
            gen_pc++;
        end
    endfunction
    function automatic void flush(input logic [29:0] a);
        exp_q.delete();
        gen_pc = a;
        refill();
    endfunction
    always @(posedge clk) refill();
    always @(posedge clk) bus.rmemdata <= bus.mem_re ? rom(bus.memaddr) : $urandom;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            iss_pc = RPC;
            issued = 0;
            dlv    = 0;
        end else if (bus.redirect) begin
            chk("redir_valid", bus.inst_valid, 0);
            chk("redir_re", bus.mem_re, 0);
            iss_pc = bus.redirect_addr;
            issued = 0;
            dlv    = 0;
        end else begin
            if (bus.mem_re) begin
                chk("issue_addr", bus.memaddr, iss_pc);
                iss_pc++;
                issued++;
            end
            chk("credit", (issued - dlv) <= DEPTH, 1);
            if (bus.inst_valid && bus.inst_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: got addr %0h expected no delivery", bus.inst_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("inst_addr", bus.inst_addr, e.a);
                    chk("inst", bus.inst, e.d);
                end
                dlv++;
                ndel++;
            end
        end
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        step();
        rst = 1'b0;
        flush(RPC);
        step();
        step();
    endtask
    task automatic release_rst();
        step();
        rst = 1'b1;
    endtask
    task automatic first_valid(input string name);
        int lat, nb;
        lat = -1;
        nb  = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.inst_valid) begin
                if (lat < 0) lat = i;
            end else if (lat >= 0) nb++;
        end
        chk(name, lat, LAT);
        chk({name, "_bubbles"}, nb, 0);
    endtask
    initial begin
        int ni, n0;
        logic [29:0] a;
        bus.redirect      = 1'b0;
        bus.redirect_addr = '0;
        bus.inst_ready    = 1'b0;
        flush(RPC);
        step();
        step();
        @(negedge clk);
        chk("rst_mem_re", bus.mem_re, 0);
        chk("rst_memaddr", bus.memaddr, 0);
        chk("rst_valid", bus.inst_valid, 0);
        chk("rst_inst", bus.inst, 0);
        chk("rst_inst_addr", bus.inst_addr, 0);
        bus.inst_ready = 1'b1;
        release_rst();
        first_valid("first_lat");
        do_reset();
        bus.inst_ready = 1'b0;
        release_rst();
        ni = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            ni += int'(bus.mem_re);
        end
        chk("stall_issues", ni, DEPTH);
        chk("stall_head", bus.inst_addr, RPC);
        chk("stall_valid", bus.inst_valid, 1);
        n0 = ndel;
        step();
        bus.inst_ready = 1'b1;
        repeat (10) step();
        chk("stall_drain", (ndel - n0) >= 8, 1);
        do_reset();
        bus.inst_ready = 1'b0;
        release_rst();
        repeat (4) step();
        bus.redirect      = 1'b1;
        bus.redirect_addr = 30'h40;
        flush(30'h40);
        @(negedge clk);
        chk("redir_3p1_valid", bus.inst_valid, 0);
        step();
        bus.redirect   = 1'b0;
        bus.inst_ready = 1'b1;
        n0 = ndel;
        repeat (10) step();
        chk("redir_drain", (ndel - n0) >= 6, 1);
        bus.redirect      = 1'b1;
        bus.redirect_addr = 30'h3FFF_FFFE;
        flush(30'h3FFF_FFFE);
        step();
        bus.redirect = 1'b0;
        n0 = ndel;
        repeat (8) step();
        chk("wrap_count", (ndel - n0) >= 4, 1);
        for (int i = 0; i < 500; i++) begin
            step();
            bus.inst_ready = 1'($urandom % 2);
            if ($urandom % 16 == 0) begin
                a = ($urandom % 2 != 0) ? 30'($urandom) : 30'h3FFF_FFFC + 30'($urandom % 4);
                bus.redirect      = 1'b1;
                bus.redirect_addr = a;
                flush(a);
            end else bus.redirect = 1'b0;
        end
        step();
        bus.redirect   = 1'b0;
        bus.inst_ready = 1'b1;
        repeat (8) step();
        #2;
        chk("pre_arst_valid", bus.inst_valid, 1);
        rst = 1'b0;
        flush(RPC);
        #1;
        chk("arst_valid", bus.inst_valid, 0);
        chk("arst_mem_re", bus.mem_re, 0);
        chk("arst_inst_addr", bus.inst_addr, 0);
        step();
        step();
        release_rst();
        first_valid("rerst_lat");
        repeat (5) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
